// File: rtl/mp64_nic_uart_phy_pkg.sv
// Shared constants and state encodings for the NIC <-> UART PHY bridge.
package mp64_nic_uart_phy_pkg;

  localparam logic [7:0]  NIC_PHY_SYNC = 8'hA5;
  localparam int unsigned NIC_PHY_MTU  = 1500;

  typedef enum logic [2:0] {
    R_SYNC, R_LEN0, R_LEN1, R_DATA, R_SKIP, R_HOLD, R_PLAY, R_GAP
  } rx_state_e;

  // Header parser used while the RX buffer is occupied
  typedef enum logic [1:0] {
    SH_IDLE, SH_LEN0, SH_LEN1, SH_SKIP
  } sh_state_e;

  typedef enum logic [2:0] {
    T_IDLE, T_CAP, T_HDR0, T_HDR1, T_HDR2, T_PAY
  } tx_state_e;

  function automatic logic len_bad(input logic [15:0] len, input int unsigned mtu);
    return (len == '0) || (32'(len) > mtu);
  endfunction

endpackage

// File: rtl/mp64_nic_uart_phy_frame_buf.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module mp64_nic_frame_buf #(
  parameter int unsigned DEPTH = 1500,
  parameter int unsigned AW    = 11
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mp64_nic_uart_phy.sv
// NIC PHY <-> byte UART bridge: SYNC + 16-bit LE length framed packets in both directions.
module mp64_nic_uart_phy
  import mp64_nic_uart_phy_pkg::*;
#(
  parameter int unsigned MTU          = NIC_PHY_MTU,
  parameter int unsigned RX_TIMEOUT   = 100000,
  parameter int unsigned LINK_TIMEOUT = 5000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx_valid_i,
  input  logic [7:0]  uart_rx_data_i,
  output logic        uart_tx_valid_o,
  output logic [7:0]  uart_tx_data_o,
  input  logic        uart_tx_ready_i,
  output logic        phy_rx_valid_o,
  output logic [7:0]  phy_rx_data_o,
  input  logic        phy_rx_ready_i,
  input  logic        phy_tx_valid_i,
  input  logic [7:0]  phy_tx_data_i,
  output logic        phy_tx_ready_o,
  output logic        phy_link_up_o,
  output logic        err_pulse_o,
  output logic [15:0] drop_count_o
);

  localparam int unsigned AW  = (MTU > 1) ? $clog2(MTU) : 1;
  localparam int unsigned RTW = $clog2(RX_TIMEOUT + 1);
  localparam int unsigned LTW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [15:0] MTU_L = 16'(MTU);

  rx_state_e rx_state_q;
  sh_state_e sh_state_q;
  tx_state_e tx_state_q;

  logic [15:0]    rx_len_q, rx_cnt_q, sh_cnt_q;
  logic [7:0]     sh_lo_q;
  logic           gap_first_q, gap_low_q;
  logic           phy_rx_valid_q, rx_err_q;
  logic [RTW-1:0] rx_idle_q;
  logic [LTW-1:0] link_q;

  logic [15:0]    tx_len_q, tx_rd_q;
  logic           tx_trunc_q, tx_err_q, phy_tx_ready_q, uart_tx_valid_q;
  logic [7:0]     tx_hdr_q;

  logic [15:0]    drop_q, drop_d;
  logic [16:0]    drop_sum;

  logic           rx_sync, rx_tmo, rx_busy;
  logic [15:0]    rx_len_in, sh_len_in;
  logic           rx_we, rx_re, tx_we, tx_re;
  logic [AW-1:0]  rx_raddr, tx_waddr, tx_raddr;
  logic [7:0]     rx_rdata, tx_rdata;

  assign rx_sync   = uart_rx_valid_i && (uart_rx_data_i == NIC_PHY_SYNC);
  assign rx_tmo    = !uart_rx_valid_i && (rx_idle_q == RTW'(RX_TIMEOUT - 1));
  assign rx_busy   = (rx_state_q == R_HOLD) || (rx_state_q == R_PLAY) || (rx_state_q == R_GAP);
  assign rx_len_in = {uart_rx_data_i, rx_len_q[7:0]};
  assign sh_len_in = {uart_rx_data_i, sh_lo_q};

  // RX buffer: read address 0 is primed during HOLD so the burst starts without a bubble
  assign rx_we    = (rx_state_q == R_DATA) && uart_rx_valid_i;
  assign rx_re    = (rx_state_q == R_HOLD) || ((rx_state_q == R_PLAY) && (rx_cnt_q != rx_len_q));
  assign rx_raddr = (rx_state_q == R_PLAY) ? rx_cnt_q[AW-1:0] : '0;

  mp64_nic_frame_buf #(.DEPTH(MTU), .AW(AW)) u_rx_buf (
    .clk     (clk),
    .we_i    (rx_we),
    .waddr_i (rx_cnt_q[AW-1:0]),
    .wdata_i (uart_rx_data_i),
    .re_i    (rx_re),
    .raddr_i (rx_raddr),
    .rdata_o (rx_rdata)
  );

  assign tx_we    = phy_tx_valid_i &&
                    ((tx_state_q == T_IDLE) || ((tx_state_q == T_CAP) && (tx_len_q < MTU_L)));
  assign tx_waddr = (tx_state_q == T_CAP) ? tx_len_q[AW-1:0] : '0;
  assign tx_re    = (tx_state_q == T_HDR2) ||
                    ((tx_state_q == T_PAY) && uart_tx_ready_i && (tx_rd_q != tx_len_q));
  assign tx_raddr = (tx_state_q == T_PAY) ? tx_rd_q[AW-1:0] : '0;

  mp64_nic_frame_buf #(.DEPTH(MTU), .AW(AW)) u_tx_buf (
    .clk     (clk),
    .we_i    (tx_we),
    .waddr_i (tx_waddr),
    .wdata_i (phy_tx_data_i),
    .re_i    (tx_re),
    .raddr_i (tx_raddr),
    .rdata_o (tx_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q     <= R_SYNC;
      sh_state_q     <= SH_IDLE;
      rx_len_q       <= '0;
      rx_cnt_q       <= '0;
      sh_lo_q        <= '0;
      sh_cnt_q       <= '0;
      gap_first_q    <= 1'b0;
      gap_low_q      <= 1'b0;
      phy_rx_valid_q <= 1'b0;
      rx_err_q       <= 1'b0;
    end else begin
      rx_err_q <= 1'b0;
      unique case (rx_state_q)
        R_SYNC: if (rx_sync) rx_state_q <= R_LEN0;
        R_LEN0: begin
          if (uart_rx_valid_i) begin
            rx_len_q[7:0] <= uart_rx_data_i;
            rx_state_q    <= R_LEN1;
          end else if (rx_tmo) begin
            rx_err_q   <= 1'b1;
            rx_state_q <= R_SYNC;
          end
        end
        R_LEN1: begin
          if (uart_rx_valid_i) begin
            rx_len_q <= rx_len_in;
            if (len_bad(rx_len_in, MTU)) begin
              rx_err_q   <= 1'b1;
              rx_cnt_q   <= rx_len_in;
              rx_state_q <= (rx_len_in == '0) ? R_SYNC : R_SKIP;
            end else begin
              rx_cnt_q   <= '0;
              rx_state_q <= R_DATA;
            end
          end else if (rx_tmo) begin
            rx_err_q   <= 1'b1;
            rx_state_q <= R_SYNC;
          end
        end
        R_DATA: begin
          if (uart_rx_valid_i) begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
            if (rx_cnt_q == rx_len_q - 16'd1) rx_state_q <= R_HOLD;
          end else if (rx_tmo) begin
            rx_err_q   <= 1'b1;
            rx_state_q <= R_SYNC;
          end
        end
        R_SKIP: begin
          if (uart_rx_valid_i) begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
            if (rx_cnt_q == 16'd1) rx_state_q <= R_SYNC;
          end else if (rx_tmo) begin
            rx_err_q   <= 1'b1;
            rx_state_q <= R_SYNC;
          end
        end
        R_HOLD: begin
          if (phy_rx_ready_i) begin
            phy_rx_valid_q <= 1'b1;
            rx_cnt_q       <= 16'd1;
            rx_state_q     <= R_PLAY;
          end
        end
        R_PLAY: begin
          if (rx_cnt_q == rx_len_q) begin
            phy_rx_valid_q <= 1'b0;
            gap_first_q    <= 1'b1;
            gap_low_q      <= 1'b0;
            rx_state_q     <= R_GAP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        R_GAP: begin
          gap_first_q <= 1'b0;
          if (!phy_rx_ready_i) gap_low_q <= 1'b1;
          // Leave only with the shadow parser idle and no byte in flight, so no header is split
          if (!gap_first_q && gap_low_q && phy_rx_ready_i &&
              (sh_state_q == SH_IDLE) && !uart_rx_valid_i)
            rx_state_q <= R_SYNC;
        end
        default: rx_state_q <= R_SYNC;
      endcase

      if (rx_busy) begin
        unique case (sh_state_q)
          SH_IDLE: if (rx_sync) sh_state_q <= SH_LEN0;
          SH_LEN0: begin
            if (uart_rx_valid_i) begin
              sh_lo_q    <= uart_rx_data_i;
              sh_state_q <= SH_LEN1;
            end else if (rx_tmo) begin
              rx_err_q   <= 1'b1;
              sh_state_q <= SH_IDLE;
            end
          end
          SH_LEN1: begin
            if (uart_rx_valid_i) begin
              rx_err_q   <= 1'b1;
              sh_cnt_q   <= sh_len_in;
              sh_state_q <= (sh_len_in == '0) ? SH_IDLE : SH_SKIP;
            end else if (rx_tmo) begin
              rx_err_q   <= 1'b1;
              sh_state_q <= SH_IDLE;
            end
          end
          SH_SKIP: begin
            if (uart_rx_valid_i) begin
              sh_cnt_q <= sh_cnt_q - 16'd1;
              if (sh_cnt_q == 16'd1) sh_state_q <= SH_IDLE;
            end else if (rx_tmo) begin
              rx_err_q   <= 1'b1;
              sh_state_q <= SH_IDLE;
            end
          end
          default: sh_state_q <= SH_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q      <= T_IDLE;
      tx_len_q        <= '0;
      tx_rd_q         <= '0;
      tx_trunc_q      <= 1'b0;
      tx_err_q        <= 1'b0;
      phy_tx_ready_q  <= 1'b1;
      uart_tx_valid_q <= 1'b0;
      tx_hdr_q        <= '0;
    end else begin
      tx_err_q <= 1'b0;
      unique case (tx_state_q)
        T_IDLE: begin
          if (phy_tx_valid_i) begin
            tx_len_q   <= 16'd1;
            tx_trunc_q <= 1'b0;
            tx_state_q <= T_CAP;
          end
        end
        T_CAP: begin
          if (phy_tx_valid_i) begin
            if (tx_len_q < MTU_L) begin
              tx_len_q <= tx_len_q + 16'd1;
            end else if (!tx_trunc_q) begin
              tx_trunc_q <= 1'b1;
              tx_err_q   <= 1'b1;
            end
          end else begin
            phy_tx_ready_q  <= 1'b0;
            uart_tx_valid_q <= 1'b1;
            tx_hdr_q        <= NIC_PHY_SYNC;
            tx_state_q      <= T_HDR0;
          end
        end
        T_HDR0: begin
          if (uart_tx_ready_i) begin
            tx_hdr_q   <= tx_len_q[7:0];
            tx_state_q <= T_HDR1;
          end
        end
        T_HDR1: begin
          if (uart_tx_ready_i) begin
            tx_hdr_q   <= tx_len_q[15:8];
            tx_state_q <= T_HDR2;
          end
        end
        T_HDR2: begin
          if (uart_tx_ready_i) begin
            tx_rd_q    <= 16'd1;
            tx_state_q <= T_PAY;
          end
        end
        T_PAY: begin
          if (uart_tx_ready_i) begin
            if (tx_rd_q == tx_len_q) begin
              uart_tx_valid_q <= 1'b0;
              phy_tx_ready_q  <= 1'b1;
              tx_state_q      <= T_IDLE;
            end else begin
              tx_rd_q <= tx_rd_q + 16'd1;
            end
          end
        end
        default: tx_state_q <= T_IDLE;
      endcase
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_q} + 17'(rx_err_q) + 17'(tx_err_q);
    drop_d   = drop_sum[16] ? '1 : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_idle_q <= '0;
      link_q    <= '0;
      drop_q    <= '0;
    end else begin
      drop_q <= drop_d;
      if (uart_rx_valid_i) begin
        rx_idle_q <= '0;
        link_q    <= LTW'(LINK_TIMEOUT);
      end else begin
        if (rx_idle_q != RTW'(RX_TIMEOUT)) rx_idle_q <= rx_idle_q + RTW'(1);
        if (link_q != '0) link_q <= link_q - LTW'(1);
      end
    end
  end

  assign phy_rx_valid_o  = phy_rx_valid_q;
  assign phy_rx_data_o   = phy_rx_valid_q ? rx_rdata : '0;
  assign uart_tx_valid_o = uart_tx_valid_q;
  assign uart_tx_data_o  = !uart_tx_valid_q ? '0 : ((tx_state_q == T_PAY) ? tx_rdata : tx_hdr_q);
  assign phy_tx_ready_o  = phy_tx_ready_q;
  assign phy_link_up_o   = (link_q != '0);
  assign err_pulse_o     = rx_err_q | tx_err_q;
  assign drop_count_o    = drop_q;

endmodule

// File: tb/tb_mp64_nic_uart_phy.sv
// Directed scoreboard bench for the NIC <-> UART PHY bridge.
module tb_mp64_nic_uart_phy;

  localparam int unsigned MTU = 1500;
  localparam int unsigned RXT = 300;
  localparam int unsigned LNK = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx_valid = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_ready;
  logic        phy_rx_valid;
  logic [7:0]  phy_rx_data;
  logic        phy_rx_ready = 1'b1;
  logic        phy_tx_valid = 1'b0;
  logic [7:0]  phy_tx_data = '0;
  logic        phy_tx_ready;
  logic        phy_link_up;
  logic        err_pulse;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  mp64_nic_uart_phy #(.MTU(MTU), .RX_TIMEOUT(RXT), .LINK_TIMEOUT(LNK)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .uart_rx_valid_i (uart_rx_valid),
    .uart_rx_data_i  (uart_rx_data),
    .uart_tx_valid_o (uart_tx_valid),
    .uart_tx_data_o  (uart_tx_data),
    .uart_tx_ready_i (uart_tx_ready),
    .phy_rx_valid_o  (phy_rx_valid),
    .phy_rx_data_o   (phy_rx_data),
    .phy_rx_ready_i  (phy_rx_ready),
    .phy_tx_valid_i  (phy_tx_valid),
    .phy_tx_data_i   (phy_tx_data),
    .phy_tx_ready_o  (phy_tx_ready),
    .phy_link_up_o   (phy_link_up),
    .err_pulse_o     (err_pulse),
    .drop_count_o    (drop_count)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];
  int rx_cycles = 0;
  int rx_run = 0;
  int last_burst = 0;
  int err_seen = 0;
  logic tx_stall = 1'b0;
  logic [7:0] tx_prev = '0;
  logic tx_rdy_en = 1'b0;
  logic [7:0] rx_e, tx_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART transmitter back-pressure: changes just after the edge, random 50%
  initial begin
    uart_tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      uart_tx_ready = tx_rdy_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (err_pulse) err_seen++;
    if (phy_rx_valid) begin
      rx_cycles++;
      rx_run++;
      if (rx_exp.size() == 0) chk("rx_unexpected_byte", 32'(rx_exp.size()), 32'd1);
      else begin
        rx_e = rx_exp.pop_front();
        chk("rx_data", 32'(phy_rx_data), 32'(rx_e));
      end
    end else if (rx_run != 0) begin
      last_burst = rx_run;
      rx_run = 0;
    end
  end

  always @(negedge clk) begin
    if (tx_stall) begin
      chk("tx_hold_valid", 32'(uart_tx_valid), 32'd1);
      chk("tx_hold_data", 32'(uart_tx_data), 32'(tx_prev));
    end
    if (uart_tx_valid && uart_tx_ready) begin
      if (tx_exp.size() == 0) chk("tx_unexpected_byte", 32'(tx_exp.size()), 32'd1);
      else begin
        tx_e = tx_exp.pop_front();
        chk("tx_data", 32'(uart_tx_data), 32'(tx_e));
      end
    end
    tx_stall = uart_tx_valid && !uart_tx_ready;
    tx_prev  = uart_tx_data;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ubyte(input logic [7:0] b);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    tick(1);
    uart_rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    uart_rx_valid = 1'b0;
    phy_tx_valid  = 1'b0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_phy_rx_valid", 32'(phy_rx_valid), 32'd0);
    chk("rst_uart_tx_valid", 32'(uart_tx_valid), 32'd0);
    chk("rst_phy_tx_ready", 32'(phy_tx_ready), 32'd1);
    chk("rst_link_up", 32'(phy_link_up), 32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
  endtask

  // NIC side: wait for one burst, check its length, then cycle ready low/high
  task automatic recv_frame(input int n);
    int k;
    k = 0;
    while (!phy_rx_valid && k < 100) begin tick(1); k++; end
    chk("rx_burst_start", 32'(phy_rx_valid), 32'd1);
    k = 0;
    while (phy_rx_valid && k < int'(MTU) + 10) begin tick(1); k++; end
    tick(1);
    chk("rx_burst_len", 32'(last_burst), 32'(n));
    chk("rx_exp_drained", 32'(rx_exp.size()), 32'd0);
    phy_rx_ready = 1'b0;
    tick(2);
    phy_rx_ready = 1'b1;
    tick(3);
  endtask

  task automatic nic_send(input int n);
    for (int i = 0; i < n; i++) begin
      phy_tx_valid = 1'b1;
      phy_tx_data  = 8'(i);
      tick(1);
    end
    phy_tx_valid = 1'b0;
  endtask

  task automatic wait_tx_drain(input int lim);
    int k;
    k = 0;
    while (tx_exp.size() != 0 && k < lim) begin tick(1); k++; end
    chk("tx_exp_drained", 32'(tx_exp.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, base;
    do_reset();

    // 1: simple 4-byte frame, NIC ready
    rx_exp.push_back(8'h11); rx_exp.push_back(8'h22);
    rx_exp.push_back(8'h33); rx_exp.push_back(8'h44);
    ubyte(8'hA5); ubyte(8'h04); ubyte(8'h00);
    ubyte(8'h11); ubyte(8'h22); ubyte(8'h33); ubyte(8'h44);
    recv_frame(4);
    chk("t1_drop_count", 32'(drop_count), 32'd0);

    // 2: frame held until NIC ready
    phy_rx_ready = 1'b0;
    rx_exp.push_back(8'h11); rx_exp.push_back(8'h22);
    rx_exp.push_back(8'h33); rx_exp.push_back(8'h44);
    base = rx_cycles;
    ubyte(8'hA5); ubyte(8'h04); ubyte(8'h00);
    ubyte(8'h11); ubyte(8'h22); ubyte(8'h33); ubyte(8'h44);
    tick(20);
    chk("t2_no_valid_while_busy", 32'(rx_cycles), 32'(base));
    phy_rx_ready = 1'b1;
    recv_frame(4);

    // 3: junk, zero length and oversize length
    e0 = err_seen;
    base = rx_cycles;
    ubyte(8'h00); ubyte(8'hFF); ubyte(8'hA5); ubyte(8'h00); ubyte(8'h00);
    ubyte(8'hA5); ubyte(8'hD0); ubyte(8'h07);
    for (int i = 0; i < 2000; i++) ubyte(8'(i));
    tick(5);
    chk("t3_err_pulses", 32'(err_seen - e0), 32'd2);
    chk("t3_drop_count", 32'(drop_count), 32'd2);
    chk("t3_no_rx_output", 32'(rx_cycles), 32'(base));
    chk("t3_link_up", 32'(phy_link_up), 32'd1);

    do_reset();

    // 4: partial packet timeout, then a 1-byte frame
    e0 = err_seen;
    ubyte(8'hA5); ubyte(8'h03); ubyte(8'h00); ubyte(8'hAA);
    tick(RXT - 10);
    chk("t4_no_early_timeout", 32'(drop_count), 32'd0);
    tick(15);
    chk("t4_timeout_drop", 32'(drop_count), 32'd1);
    chk("t4_timeout_err", 32'(err_seen - e0), 32'd1);
    rx_exp.push_back(8'h5C);
    ubyte(8'hA5); ubyte(8'h01); ubyte(8'h00); ubyte(8'h5C);
    recv_frame(1);

    // 5: NIC TX 60 bytes with UART back-pressure
    tx_rdy_en = 1'b1;
    chk("t5_tx_ready_idle", 32'(phy_tx_ready), 32'd1);
    tx_exp.push_back(8'hA5); tx_exp.push_back(8'h3C); tx_exp.push_back(8'h00);
    for (int i = 0; i < 60; i++) tx_exp.push_back(8'(i));
    nic_send(60);
    tick(2);
    chk("t5_tx_ready_busy", 32'(phy_tx_ready), 32'd0);
    wait_tx_drain(2000);
    tick(2);
    chk("t5_tx_ready_back", 32'(phy_tx_ready), 32'd1);
    chk("t5_uart_idle", 32'(uart_tx_valid), 32'd0);

    // 6: oversize TX frame truncated to MTU, then link timeout
    do_reset();
    e0 = err_seen;
    tx_exp.push_back(8'hA5); tx_exp.push_back(8'hDC); tx_exp.push_back(8'h05);
    for (int i = 0; i < int'(MTU); i++) tx_exp.push_back(8'(i));
    nic_send(1502);
    wait_tx_drain(8000);
    tick(2);
    chk("t6_drop_count", 32'(drop_count), 32'd1);
    chk("t6_err_pulses", 32'(err_seen - e0), 32'd1);
    chk("t6_tx_ready_back", 32'(phy_tx_ready), 32'd1);
    chk("t6_link_down_after_reset", 32'(phy_link_up), 32'd0);
    ubyte(8'h00);
    chk("t6_link_up", 32'(phy_link_up), 32'd1);
    tick(LNK - 10);
    chk("t6_link_still_up", 32'(phy_link_up), 32'd1);
    tick(20);
    chk("t6_link_dropped", 32'(phy_link_up), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
